// File: rtl/latch_wr_sched_pkg.sv
// Shared types and sizing helpers for the latch write scheduler.
package latch_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_OPEN  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  function automatic int cnt_width(input int open_cycles);
    return (open_cycles < 1) ? 1 : $clog2(open_cycles + 1);
  endfunction

  function automatic int ptr_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/latch_wr_sched_rr_arbiter.sv
// Combinational one-hot arbiter: round-robin from ptr_i when LATCH_SCHED_RR_EN
// is defined, otherwise fixed priority (lowest index wins, no pointer port).
module rr_arbiter
  import latch_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]             req_i,
`ifdef LATCH_SCHED_RR_EN
  input  logic [ptr_width(NUM_REQ)-1:0]  ptr_i,
`endif
  output logic [NUM_REQ-1:0]             gnt_o
);

  logic found;

`ifdef LATCH_SCHED_RR_EN
  // Offset i is the distance from the pointer; the first set requester wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req_i[j] && (((int'(ptr_i) + i) % NUM_REQ) == j)) begin
          gnt_o[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req_i[j]) begin
        gnt_o[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/latch_wr_sched.sv
// Write scheduler for a shared transparent-latch bank: arbitrate, capture data,
// then sequence the gate SETUP -> OPEN -> HOLD. Optional macro: LATCH_SCHED_RR_EN.
module latch_wr_sched
  import latch_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int OPEN_CYCLES = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic                      latch_en_o,
  output logic [DATA_W-1:0]         latch_d_o,
  output logic                      busy_o
);

  localparam int CNT_W = cnt_width(OPEN_CYCLES);
  localparam int PTR_W = ptr_width(NUM_REQ);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               latch_en_q, latch_en_d;
  logic [DATA_W-1:0]  latch_d_q, latch_d_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] arb_gnt;

`ifdef LATCH_SCHED_RR_EN
  logic [PTR_W-1:0]   ptr_q, ptr_d;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (req_i),
`ifdef LATCH_SCHED_RR_EN
    .ptr_i   (ptr_q),
`endif
    .gnt_o   (arb_gnt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    latch_d_d = latch_d_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          state_d = ST_SETUP;
          gnt_d   = arb_gnt;
          for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_gnt[k]) latch_d_d = data_i[k*DATA_W +: DATA_W];
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_OPEN;
        cnt_d   = CNT_W'(OPEN_CYCLES - 1);
      end
      ST_OPEN: begin
        if (cnt_q == '0) state_d = ST_HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered versions of what the next state implies.
    latch_en_d = (state_d == ST_OPEN);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_HOLD) ? gnt_d : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      latch_en_q <= 1'b0;
      latch_d_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      latch_en_q <= latch_en_d;
      latch_d_q  <= latch_d_d;
      busy_q     <= busy_d;
    end
  end

`ifdef LATCH_SCHED_RR_EN
  // Pointer advances past the winner only when a grant is actually issued.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && (|req_i)) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (arb_gnt[k]) ptr_d = PTR_W'((k + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign latch_en_o = latch_en_q;
  assign latch_d_o  = latch_d_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_latch_wr_sched.sv
// Directed bench for latch_wr_sched (NUM_REQ=4, DATA_W=8, OPEN_CYCLES=2).
module tb_latch_wr_sched;

  logic        clk_i;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic [3:0]  gnt_o;
  logic [3:0]  done_o;
  logic        latch_en_o;
  logic [7:0]  latch_d_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] prev_d = '0;

  latch_wr_sched #(
    .NUM_REQ     (4),
    .DATA_W      (8),
    .OPEN_CYCLES (2)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .data_i     (data_i),
    .gnt_o      (gnt_o),
    .done_o     (done_o),
    .latch_en_o (latch_en_o),
    .latch_d_o  (latch_d_o),
    .busy_o     (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Gate-open invariant: stable data and a one-hot grant while transparent.
  always @(negedge clk_i) begin
    if (!rst_i && latch_en_o) begin
      check_val("inv_d_stable", 32'(latch_d_o), 32'(prev_d));
      check_val("inv_gnt_onehot", 32'($onehot(gnt_o)), 32'd1);
    end
    prev_d = latch_d_o;
  end

  task automatic check_idle(input logic [7:0] d);
    check_val("idle_busy", 32'(busy_o), 32'd0);
    check_val("idle_gnt", 32'(gnt_o), 32'd0);
    check_val("idle_done", 32'(done_o), 32'd0);
    check_val("idle_en", 32'(latch_en_o), 32'd0);
    check_val("idle_d", 32'(latch_d_o), 32'(d));
  endtask

  // Called at the negedge before the arbitration edge; returns at the HOLD negedge.
  task automatic expect_txn(input int idx, input logic [7:0] d,
                            input logic [3:0] open_req, input logic [31:0] open_data);
    logic [3:0] g;
    g = 4'(1 << idx);
    @(negedge clk_i);
    check_val("setup_gnt", 32'(gnt_o), 32'(g));
    check_val("setup_d", 32'(latch_d_o), 32'(d));
    check_val("setup_en", 32'(latch_en_o), 32'd0);
    check_val("setup_busy", 32'(busy_o), 32'd1);
    check_val("setup_done", 32'(done_o), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      check_val("open_en", 32'(latch_en_o), 32'd1);
      check_val("open_gnt", 32'(gnt_o), 32'(g));
      check_val("open_d", 32'(latch_d_o), 32'(d));
      check_val("open_done", 32'(done_o), 32'd0);
      check_val("open_busy", 32'(busy_o), 32'd1);
      if (c == 0) begin
        req_i  = open_req;
        data_i = open_data;
      end
    end
    @(negedge clk_i);
    check_val("hold_en", 32'(latch_en_o), 32'd0);
    check_val("hold_done", 32'(done_o), 32'(g));
    check_val("hold_gnt", 32'(gnt_o), 32'(g));
    check_val("hold_d", 32'(latch_d_o), 32'(d));
    check_val("hold_busy", 32'(busy_o), 32'd1);
  endtask

  initial begin
    int exp_idx [5];
    logic [7:0] d;
`ifdef LATCH_SCHED_RR_EN
    exp_idx = '{0, 1, 2, 3, 0};
`else
    exp_idx = '{0, 0, 0, 0, 0};
`endif
    rst_i  = 1'b1;
    req_i  = '0;
    data_i = '0;
    repeat (2) @(negedge clk_i);
    check_idle(8'h00);
    rst_i = 1'b0;

    // All four requesting continuously.
    req_i  = 4'b1111;
    data_i = 32'h44332211;
    for (int t = 0; t < 5; t++) begin
      d = data_i[exp_idx[t]*8 +: 8];
      expect_txn(exp_idx[t], d, 4'b1111, data_i);
      if (t < 4) begin
        @(negedge clk_i);
        check_idle(d);
      end
    end
    req_i = '0;
    @(negedge clk_i);
    check_idle(data_i[exp_idx[4]*8 +: 8]);

    // Single request from requester 0.
    req_i  = 4'b0001;
    data_i = 32'h000000A5;
    expect_txn(0, 8'hA5, 4'b0001, data_i);
    req_i = '0;
    @(negedge clk_i);
    check_idle(8'hA5);

    // Data changes during OPEN; captured value must persist until next grant.
    req_i  = 4'b0010;
    data_i = 32'h00003C00;
    expect_txn(1, 8'h3C, 4'b0010, 32'h0000FF00);
    req_i = '0;
    @(negedge clk_i);
    check_idle(8'h3C);
    @(negedge clk_i);
    check_idle(8'h3C);
    req_i = 4'b0010;
    expect_txn(1, 8'hFF, 4'b0010, data_i);
    req_i = '0;
    @(negedge clk_i);
    check_idle(8'hFF);

    // Request drops mid-OPEN; transaction still completes.
    req_i  = 4'b0100;
    data_i = 32'h005A0000;
    expect_txn(2, 8'h5A, 4'b0000, data_i);
    @(negedge clk_i);
    check_idle(8'h5A);

    // Asynchronous reset during OPEN.
    req_i  = 4'b0001;
    data_i = 32'h00000077;
    @(negedge clk_i);
    check_val("rst_setup_gnt", 32'(gnt_o), 32'd1);
    check_val("rst_setup_d", 32'(latch_d_o), 32'h77);
    req_i = '0;
    @(negedge clk_i);
    check_val("rst_open_en", 32'(latch_en_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check_val("async_en", 32'(latch_en_o), 32'd0);
    check_val("async_gnt", 32'(gnt_o), 32'd0);
    check_val("async_busy", 32'(busy_o), 32'd0);
    check_val("async_done", 32'(done_o), 32'd0);
    check_val("async_d", 32'(latch_d_o), 32'd0);
    repeat (2) begin
      @(negedge clk_i);
      check_val("rst_no_done", 32'(done_o), 32'd0);
      check_val("rst_en_low", 32'(latch_en_o), 32'd0);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    check_idle(8'h00);
    req_i  = 4'b1000;
    data_i = 32'hC3000000;
    expect_txn(3, 8'hC3, 4'b1000, data_i);
    req_i = '0;
    @(negedge clk_i);
    check_idle(8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
